// File: rtl/qspi_pkg.sv
// Shared QSPI definitions used by both the initiator and the memory responder.
// Holds the frame-decoder states, the command opcodes and the address length.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } qspi_state_t;

  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;

  localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_mem_responder_sync2.sv
// Two-flop synchronizer for bringing asynchronous pins into the clk domain.
// RST_VAL sets the value both stages take while rst_n is low.
module sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI target that serves quad read (0xEB) and write (0x38) frames from an
// internal byte memory; a backdoor port preloads images and wins on conflicts.
module qspi_mem_responder
  import qspi_pkg::*;
#(
  parameter  int DEPTH = 256,
  parameter  int DUMMY = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_n,
  input  logic          sclk,
  input  logic [3:0]    io_in,
  output logic [3:0]    io_out,
  output logic [3:0]    io_oe,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          busy,
  output logic          collision
);

  localparam logic [2:0] ADDR_LAST  = 3'(ADDR_NIBBLES - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);

  logic       cs_s;
  logic       sclk_s;
  logic [3:0] io_s;

  // cs_n resets to "low" so a reset taken with cs_n held low never sees a
  // fall; decoding resumes only after the initiator deselects and reselects.
  sync2 #(.W(1), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_s)
  );
  sync2 #(.W(1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
  );
  sync2 #(.W(4), .RST_VAL(4'h0)) u_sync_io (
    .clk(clk), .rst_n(rst_n), .d_i(io_in), .q_o(io_s)
  );

  logic        cs_prev_q, sclk_prev_q;
  logic        cs_rise, cs_fall, sclk_rise, sclk_fall;

  qspi_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  dummy_q, dummy_d;
  logic        hi_q, hi_d;
  logic [3:0]  wr_hi_q, wr_hi_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic        wr_pend_q, wr_pend_d;
  logic [3:0]  io_out_q, io_out_d;
  logic        io_oe_q, io_oe_d;
  logic        busy_q, busy_d;
  logic        collision_q, collision_d;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  rd_data_q;

  assign cs_rise   = ~cs_prev_q & cs_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    dummy_d     = dummy_q;
    hi_d        = hi_q;
    wr_hi_d     = wr_hi_q;
    wr_byte_d   = wr_byte_q;
    wr_pend_d   = 1'b0;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    busy_d      = busy_q;
    collision_d = wr_pend_q & load_we;

    // A completed byte always advances the address, even when the load port
    // stole the memory cycle.
    if (wr_pend_q) begin
      addr_d = addr_q + 24'd1;
    end

    if (cs_rise) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      hi_d     = 1'b1;
      io_out_d = 4'h0;
      io_oe_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = 3'd0;
            hi_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_d = {cmd_q[3:0], io_s};
            if (cnt_q == 3'd1) begin
              cnt_d   = 3'd0;
              state_d = ST_ADDR;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_d = {addr_q[19:0], io_s};
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = 3'd0;
              dummy_d = 8'd0;
              if (cmd_q == CMD_READ) begin
                if (DUMMY == 0) state_d = ST_RD_DATA;
                else            state_d = ST_DUMMY;
              end else if (cmd_q == CMD_WRITE) begin
                state_d = ST_WR_DATA;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (sclk_rise) begin
            if (dummy_q == DUMMY_LAST) state_d = ST_RD_DATA;
            else                       dummy_d = dummy_q + 8'd1;
          end
        end
        ST_RD_DATA: begin
          // rd_data_q follows addr_q one clk later, long before the next fall.
          if (sclk_fall) begin
            io_oe_d = 1'b1;
            if (hi_q) begin
              io_out_d = rd_data_q[7:4];
              hi_d     = 1'b0;
            end else begin
              io_out_d = rd_data_q[3:0];
              hi_d     = 1'b1;
              addr_d   = addr_q + 24'd1;
            end
          end
        end
        ST_WR_DATA: begin
          if (sclk_rise) begin
            if (hi_q) begin
              wr_hi_d = io_s;
              hi_d    = 1'b0;
            end else begin
              wr_byte_d = {wr_hi_q, io_s};
              wr_pend_d = 1'b1;
              hi_d      = 1'b1;
            end
          end
        end
        ST_IGNORE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      cmd_q       <= 8'h00;
      addr_q      <= 24'h0;
      dummy_q     <= 8'd0;
      hi_q        <= 1'b1;
      wr_hi_q     <= 4'h0;
      wr_byte_q   <= 8'h00;
      wr_pend_q   <= 1'b0;
      io_out_q    <= 4'h0;
      io_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      dummy_q     <= dummy_d;
      hi_q        <= hi_d;
      wr_hi_q     <= wr_hi_d;
      wr_byte_q   <= wr_byte_d;
      wr_pend_q   <= wr_pend_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      busy_q      <= busy_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end else if (wr_pend_q && rst_n) begin
      mem[addr_q[AW-1:0]] <= wr_byte_q;
    end
    rd_data_q <= mem[addr_q[AW-1:0]];
  end

  assign io_out    = io_out_q;
  assign io_oe     = {4{io_oe_q}};
  assign busy      = busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: drives QSPI frames with sclk half
// periods of 6 clk and checks bus data, enables, busy and collision.
module tb_qspi_mem_responder;

  localparam int DEPTH = 256;
  localparam int DUMMY = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       sclk;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       load_we;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       busy;
  logic       collision;

  int total = 0;
  int bad   = 0;

  qspi_mem_responder #(.DEPTH(DEPTH), .DUMMY(DUMMY)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick(1);
    load_we = 1'b0;
    $display("txn load  addr=%02h data=%02h", a, d);
  endtask

  // One sclk period; rd/oe are sampled just before the rising edge.
  task automatic sclk_cycle(input logic [3:0] nib, output logic [3:0] rd, output logic [3:0] oe);
    io_in = nib;
    tick(6);
    rd = io_out;
    oe = io_oe;
    sclk = 1'b1;
    tick(6);
    sclk = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] cmd, input logic [23:0] a);
    logic [3:0] rd, oe;
    logic [31:0] hdr;
    hdr = {cmd, a};
    cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) sclk_cycle(hdr[i*4 +: 4], rd, oe);
  endtask

  task automatic end_frame();
    tick(2);
    cs_n  = 1'b1;
    io_in = 4'h0;
    tick(8);
  endtask

  task automatic qspi_read2(input logic [23:0] a, input logic [15:0] exp, input string tag);
    logic [3:0] rd, oe;
    logic [3:0] dum_oe, dat_oe;
    logic [15:0] data;
    start_frame(8'hEB, a);
    dum_oe = 4'h0;
    for (int i = 0; i < DUMMY; i++) begin
      sclk_cycle(4'h0, rd, oe);
      dum_oe |= oe;
    end
    dat_oe = 4'hF;
    data   = 16'h0;
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(4'h0, rd, oe);
      data   = {data[11:0], rd};
      dat_oe &= oe;
    end
    end_frame();
    $display("txn read  addr=%06h data=%04h", a, data);
    chk({tag, "_data"}, {16'h0, data}, {16'h0, exp});
    chk({tag, "_oe_dummy"}, {28'h0, dum_oe}, 32'h0);
    chk({tag, "_oe_data"}, {28'h0, dat_oe}, 32'hF);
    chk({tag, "_oe_after"}, {28'h0, io_oe}, 32'h0);
    chk({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic qspi_write2(input logic [23:0] a, input logic [15:0] d);
    logic [3:0] rd, oe;
    start_frame(8'h38, a);
    for (int i = 3; i >= 0; i--) sclk_cycle(d[i*4 +: 4], rd, oe);
    end_frame();
    $display("txn write addr=%06h data=%04h", a, d);
  endtask

  initial begin
    logic [3:0] rd, oe, oe_acc;
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; io_in = 4'h0;
    load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00;

    // Reset with sclk toggling and cs_n idle.
    for (int i = 0; i < 4; i++) begin
      tick(1);
      sclk = ~sclk;
    end
    chk("rst_io_oe", {28'h0, io_oe}, 32'h0);
    chk("rst_io_out", {28'h0, io_out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_collision", {31'h0, collision}, 32'h0);
    rst_n = 1'b1;
    sclk  = 1'b0;
    oe_acc = 4'h0;
    for (int i = 0; i < 3; i++) begin
      sclk_cycle(4'h0, rd, oe);
      oe_acc |= oe;
    end
    $display("txn reset released, idle sclk toggling");
    chk("idle_oe", {28'h0, oe_acc}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // Backdoor load then quad read.
    load(8'h10, 8'hA5);
    load(8'h11, 8'h3C);
    load(8'h00, 8'h00);
    load(8'h01, 8'h00);
    load(8'h20, 8'h66);
    load(8'h21, 8'h99);
    load(8'h31, 8'h44);
    qspi_read2(24'h000010, 16'hA53C, "rd10");
    qspi_read2(24'h123410, 16'hA53C, "rd_hiaddr");

    // Write across the top of memory, read back with wrap.
    qspi_write2(24'h0000FF, 16'h1122);
    qspi_read2(24'h0000FF, 16'h1122, "rd_wrap");
    qspi_read2(24'h000000, 16'h2200, "rd_00");

    // Abort after a single write nibble.
    start_frame(8'h38, 24'h000020);
    sclk_cycle(4'h7, rd, oe);
    tick(2);
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    cs_n = 1'b1;
    tick(4);
    $display("txn abort write addr=000020 after one nibble");
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_oe", {28'h0, io_oe}, 32'h0);
    tick(4);
    qspi_read2(24'h000020, 16'h6699, "rd_abort");

    // Unknown command: 16 sclk periods without drive.
    start_frame(8'h9F, 24'h000010);
    oe_acc = 4'h0;
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(4'h0, rd, oe);
      oe_acc |= oe;
    end
    oe_acc |= io_oe;
    chk("ign_busy", {31'h0, busy}, 32'h1);
    end_frame();
    $display("txn ignore cmd=9F");
    chk("ign_oe", {28'h0, oe_acc}, 32'h0);
    chk("ign_busy_after", {31'h0, busy}, 32'h0);

    // Collision: load lands in the bus-write commit clk.
    start_frame(8'h38, 24'h000030);
    sclk_cycle(4'hC, rd, oe);
    io_in = 4'h3;
    tick(6);
    sclk = 1'b1;
    tick(3);
    chk("coll_before", {31'h0, collision}, 32'h0);
    load_we = 1'b1; load_addr = 8'h30; load_data = 8'h5A;
    tick(1);
    load_we = 1'b0;
    chk("coll_pulse", {31'h0, collision}, 32'h1);
    tick(1);
    chk("coll_after", {31'h0, collision}, 32'h0);
    tick(2);
    sclk = 1'b0;
    end_frame();
    $display("txn collision addr=000030 bus=C3 load=5A");
    qspi_read2(24'h000030, 16'h5A44, "rd_coll");

    // Reset in the middle of a read with cs_n held low.
    start_frame(8'hEB, 24'h000010);
    for (int i = 0; i < DUMMY; i++) sclk_cycle(4'h0, rd, oe);
    sclk_cycle(4'h0, rd, oe);
    chk("mid_oe_data", {28'h0, oe}, 32'hF);
    chk("mid_nib", {28'h0, rd}, 32'hA);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_oe", {28'h0, io_oe}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    oe_acc = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(4'h5, rd, oe);
      oe_acc |= oe;
    end
    chk("mid_hold_oe", {28'h0, oe_acc}, 32'h0);
    chk("mid_hold_busy", {31'h0, busy}, 32'h0);
    end_frame();
    $display("txn reset mid-read, cs_n held low");
    qspi_read2(24'h000010, 16'hA53C, "rd_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
